// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: RUN/DWAIT/HALT FSM plus Mealy enable/flush decode.
// Optional perf counters (stall/flush/dwait) are compiled in when PIPE_PERF_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int ZERO_REG_CHK = 1,
   parameter int CNT_W        = 32
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       ihit,
   input  logic       dhit,
   input  logic       mem_dREN,
   input  logic       mem_dWEN,
   input  logic       ex_dREN,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       ex_redirect,
   input  logic       wb_halt,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       ifid_flush,
   output logic       idex_en,
   output logic       idex_flush,
   output logic       exmem_en,
   output logic       exmem_flush,
   output logic       memwb_en,
   output logic       halt_out
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic [CNT_W-1:0] dwait_cycles
`endif
);

   typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

   state_t state_reg, state_next;

   logic memreq, luse, redirect_taken;
   logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
   logic exmem_en_c, exmem_flush_c, memwb_en_c, halt_c;

   assign memreq = mem_dREN | mem_dWEN;
   assign luse   = ex_dREN && ((ex_rt == id_rs) || (ex_rt == id_rt)) &&
                   !((ZERO_REG_CHK != 0) && (ex_rt == 5'd0));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_reg <= RUN;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      pc_en_c        = 1'b0;
      ifid_en_c      = 1'b0;
      ifid_flush_c   = 1'b0;
      idex_en_c      = 1'b0;
      idex_flush_c   = 1'b0;
      exmem_en_c     = 1'b0;
      exmem_flush_c  = 1'b0;
      memwb_en_c     = 1'b0;
      halt_c         = 1'b0;
      redirect_taken = 1'b0;
      case (state_reg)
         HALT: halt_c = 1'b1;
         RUN, DWAIT: begin
            if (state_reg == DWAIT && !dhit) begin
               state_next = DWAIT;
            end else if (wb_halt) begin
               halt_c     = 1'b1;
               state_next = HALT;
            end else if (state_reg == RUN && memreq && !dhit) begin
               state_next = DWAIT;
            end else begin
               // Access satisfied (or none pending): normal hazard priority.
               state_next = RUN;
               idex_en_c  = 1'b1;
               exmem_en_c = 1'b1;
               memwb_en_c = 1'b1;
               ifid_en_c  = 1'b1;
               if (ex_redirect) begin
                  redirect_taken = 1'b1;
                  pc_en_c        = 1'b1;
                  ifid_flush_c   = 1'b1;
                  idex_flush_c   = 1'b1;
               end else if (luse) begin
                  ifid_en_c    = 1'b0;
                  idex_flush_c = 1'b1;
               end else if (!ihit) begin
                  ifid_flush_c = 1'b1;
               end else begin
                  pc_en_c = 1'b1;
               end
            end
         end
         default: state_next = RUN;
      endcase
   end

   // Outputs are forced low for as long as reset is held.
   assign pc_en       = pc_en_c       & nRST;
   assign ifid_en     = ifid_en_c     & nRST;
   assign ifid_flush  = ifid_flush_c  & nRST;
   assign idex_en     = idex_en_c     & nRST;
   assign idex_flush  = idex_flush_c  & nRST;
   assign exmem_en    = exmem_en_c    & nRST;
   assign exmem_flush = exmem_flush_c & nRST;
   assign memwb_en    = memwb_en_c    & nRST;
   assign halt_out    = halt_c        & nRST;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_reg, flush_reg, dwait_reg;
   logic             live;

   assign live = (state_reg != HALT);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_reg <= '0;
         flush_reg <= '0;
         dwait_reg <= '0;
      end else begin
         if (live && !pc_en_c && stall_reg != '1)
            stall_reg <= stall_reg + 1'b1;
         if (live && redirect_taken && flush_reg != '1)
            flush_reg <= flush_reg + 1'b1;
         if (state_reg == DWAIT && !dhit && dwait_reg != '1)
            dwait_reg <= dwait_reg + 1'b1;
      end
   end

   assign stall_cycles = stall_reg;
   assign flush_events = flush_reg;
   assign dwait_cycles = dwait_reg;
`else
   // CNT_W only sizes the perf counters; nothing to build without them.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances differing only in ZERO_REG_CHK,
// outputs packed into one vector and compared against hand-derived constants.
module tb_pipeline_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_redirect, wb_halt;
   logic [4:0] ex_rt, id_rs, id_rt;

   logic pc0, ife0, iff0, ide0, idf0, exe0, exf0, mwe0, h0;
   logic pc1, ife1, iff1, ide1, idf1, exe1, exf1, mwe1, h1;

`ifdef PIPE_PERF_EN
   logic [31:0] sc0, fe0, dc0, sc1, fe1, dc1;
`endif

   int total = 0;
   int bad   = 0;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halt_out}
   localparam logic [8:0] V_ZERO = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] V_RUN  = 9'b1_1_0_1_0_1_0_1_0;
   localparam logic [8:0] V_REDR = 9'b1_1_1_1_1_1_0_1_0;
   localparam logic [8:0] V_LUSE = 9'b0_0_0_1_1_1_0_1_0;
   localparam logic [8:0] V_MISS = 9'b0_1_1_1_0_1_0_1_0;
   localparam logic [8:0] V_HALT = 9'b0_0_0_0_0_0_0_0_1;

   wire [8:0] out0 = {pc0, ife0, iff0, ide0, idf0, exe0, exf0, mwe0, h0};
   wire [8:0] out1 = {pc1, ife1, iff1, ide1, idf1, exe1, exf1, mwe1, h1};

   pipeline_hazard_ctrl #(.ZERO_REG_CHK(1), .CNT_W(32)) u_dut0 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
      .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .ex_redirect(ex_redirect), .wb_halt(wb_halt),
      .pc_en(pc0), .ifid_en(ife0), .ifid_flush(iff0), .idex_en(ide0), .idex_flush(idf0),
      .exmem_en(exe0), .exmem_flush(exf0), .memwb_en(mwe0), .halt_out(h0)
`ifdef PIPE_PERF_EN
      , .stall_cycles(sc0), .flush_events(fe0), .dwait_cycles(dc0)
`endif
   );

   pipeline_hazard_ctrl #(.ZERO_REG_CHK(0), .CNT_W(32)) u_dut1 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
      .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .ex_redirect(ex_redirect), .wb_halt(wb_halt),
      .pc_en(pc1), .ifid_en(ife1), .ifid_flush(iff1), .idex_en(ide1), .idex_flush(idf1),
      .exmem_en(exe1), .exmem_flush(exf1), .memwb_en(mwe1), .halt_out(h1)
`ifdef PIPE_PERF_EN
      , .stall_cycles(sc1), .flush_events(fe1), .dwait_cycles(dc1)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b expected=%b", tag, got[8:0], exp[8:0]);
      end else begin
         $display("ok   %s: %b", tag, got[8:0]);
      end
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_dREN = 1'b0;
      ex_redirect = 1'b0; wb_halt = 1'b0; ex_rt = 5'd0; id_rs = 5'd1; id_rt = 5'd2;
   endtask

   // Inputs are already set on the falling edge; sample mid-low-phase, then advance one cycle.
   task automatic cyc(input string tag, input logic [8:0] exp);
      #1;
      chk(tag, {23'd0, out0}, {23'd0, exp});
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      nRST = 1'b0;
      idle();
      @(negedge CLK);
      #1;
      chk("reset_outputs_low", {23'd0, out0}, {23'd0, V_ZERO});
      @(negedge CLK);
      nRST = 1'b1;
      cyc("first_cycle_run", V_RUN);

      // Load-use on rs, then on rt, then cleared
      ex_dREN = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      cyc("luse_rs", V_LUSE);
      idle();
      cyc("after_luse", V_RUN);
      ex_dREN = 1'b1; ex_rt = 5'd7; id_rt = 5'd7;
      cyc("luse_rt", V_LUSE);
      idle(); ex_rt = 5'd9; id_rs = 5'd9;
      cyc("no_load_no_stall", V_RUN);

      // r0 destination: ignored with ZERO_REG_CHK=1, stalls with 0
      idle(); ex_dREN = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      chk("zero_reg_chk0_stall", {23'd0, out1}, {23'd0, V_LUSE});
      cyc("zero_reg_chk1_nostall", V_RUN);

      idle(); ihit = 1'b0;
      cyc("fetch_miss", V_MISS);

      // Redirect beats load-use and fetch miss
      idle(); ihit = 1'b0; ex_redirect = 1'b1; ex_dREN = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
      cyc("redirect_wins", V_REDR);

      // Memory wait: one RUN freeze plus two DWAIT freezes, redirect ignored while waiting
      idle(); mem_dREN = 1'b1;
      cyc("dwait_enter", V_ZERO);
      ex_redirect = 1'b1; ihit = 1'b0;
      cyc("dwait_hold1", V_ZERO);
      cyc("dwait_hold2", V_ZERO);
      idle(); mem_dREN = 1'b1; dhit = 1'b1;
      cyc("dwait_release", V_RUN);
      idle();
      cyc("back_in_run", V_RUN);

      // Store wait released together with a redirect
      mem_dWEN = 1'b1; ex_redirect = 1'b1;
      cyc("memwait_beats_redirect", V_ZERO);
      dhit = 1'b1;
      cyc("dwait_release_redirect", V_REDR);

      // Access hitting in the same cycle it is requested, ihit and dhit together
      idle(); mem_dREN = 1'b1; dhit = 1'b1;
      cyc("memreq_dhit_same_cycle", V_RUN);

      // Halt reached while waiting on memory
      idle(); mem_dWEN = 1'b1;
      cyc("dwait_before_halt", V_ZERO);
      wb_halt = 1'b1;
      cyc("dwait_no_halt_until_dhit", V_ZERO);
      dhit = 1'b1;
      cyc("dwait_halt_on_dhit", V_HALT);
      idle(); ex_redirect = 1'b1;
      cyc("halt_sticky_from_dwait", V_HALT);

      // Reset out of HALT, then halt from RUN
      nRST = 1'b0;
      #1;
      chk("reset_mid_halt", {23'd0, out0}, {23'd0, V_ZERO});
      @(negedge CLK);
      nRST = 1'b1; idle();
      cyc("run_after_reset", V_RUN);
      wb_halt = 1'b1; mem_dREN = 1'b1; ex_redirect = 1'b1;
      cyc("halt_beats_all", V_HALT);
      for (int i = 0; i < 4; i++) begin
         idle(); ihit = i[0]; dhit = ~i[0]; mem_dREN = i[1];
         cyc("halt_sticky", V_HALT);
      end
      nRST = 1'b0;
      @(negedge CLK);
      nRST = 1'b1; idle();
      cyc("run_after_second_reset", V_RUN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
